// File: rtl/mera_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mera_bus_pkg
// Description : Shared types and idle-level constants for MERA-400 bus masters
// Revision    : 1.0 - initial release
// ============================================================================

package mera_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RELEASE = 2'd2
    } bus_state_t;

    // Active-low bus: an idle line reads all ones
    localparam logic [3:0]  NB_IDLE   = 4'hF;
    localparam logic [15:0] WORD_IDLE = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/bus_timeout.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout
// Description : Clearable up-counter that flags terminal count TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================

module bus_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    // Saturates at terminal count so tc stays asserted until cleared
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tc = (r_cnt == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master
// Description : Single-word read/write master for the active-low memory bus.
//               MERA-400 bit 0 (MSB) maps to vector bit [N-1] here.
// Revision    : 1.0 - initial release
// ============================================================================

module mem_bus_master
    import mera_bus_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  nb,
    input  logic [15:0] ad,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        alarm,
    output logic [15:0] rdata,
    output logic [3:0]  nb_,
    output logic [15:0] ad_,
    output logic [15:0] rdt_,
    output logic        r_,
    output logic        w_,
    output logic        s_,
    input  logic [15:0] ddt_,
    input  logic        ok_
);

    bus_state_t r_state;
    logic       r_is_write;
    logic       r_alarm_flag;
    logic       w_tc;
    logic       w_cnt_clr;
    logic       w_cnt_en;

    // Counter restarts on every state entry so each wait gets a full budget
    always_comb begin
        w_cnt_clr = (r_state == IDLE) || ((r_state == STROBE) && (!ok_ || w_tc));
        w_cnt_en  = (r_state != IDLE);
    end

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst_(rst_),
        .clr (w_cnt_clr),
        .en  (w_cnt_en),
        .tc  (w_tc)
    );

    assign s_ = 1'b1;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state      <= IDLE;
            r_is_write   <= 1'b0;
            r_alarm_flag <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            alarm        <= 1'b0;
            rdata        <= '0;
            nb_          <= NB_IDLE;
            ad_          <= WORD_IDLE;
            rdt_         <= WORD_IDLE;
            r_           <= 1'b1;
            w_           <= 1'b1;
        end else begin
            done  <= 1'b0;
            alarm <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        nb_          <= ~nb;
                        ad_          <= ~ad;
                        rdt_         <= we ? ~wdata : WORD_IDLE;
                        r_is_write   <= we;
                        r_           <= we;
                        w_           <= ~we;
                        r_alarm_flag <= 1'b0;
                        busy         <= 1'b1;
                        r_state      <= STROBE;
                    end
                end
                STROBE: begin
                    if (!ok_) begin
                        if (!r_is_write) begin
                            rdata <= ~ddt_;
                        end
                        r_      <= 1'b1;
                        w_      <= 1'b1;
                        r_state <= RELEASE;
                    end else if (w_tc) begin
                        r_           <= 1'b1;
                        w_           <= 1'b1;
                        r_alarm_flag <= 1'b1;
                        r_state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Lines stay put until the slave lets go of ok_ (or gives up)
                    if (ok_ || w_tc) begin
                        done    <= 1'b1;
                        alarm   <= r_alarm_flag | ~ok_;
                        busy    <= 1'b0;
                        nb_     <= NB_IDLE;
                        ad_     <= WORD_IDLE;
                        rdt_    <= WORD_IDLE;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_      <= 1'b1;
                    w_      <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_master.md
# mem_bus_master

CPU-side master for the MERA-400 style active-low memory bus. Accepts single-word read/write requests on a simple active-high request port and runs the full bus handshake against a memory slave such as the SRAM-backed memory module:
- drive nb_/ad_/rdt_;
- assert r_ or w_;
- wait for ok_ and capture ddt_;
- release the strobe and wait for ok_ to go high.

It sits directly upstream of the memory module. A missing answer is reported as a bus alarm after a bounded wait.

## Interface
- TIMEOUT, 64: cycles to wait for ok_ to assert, and separately to deassert, before raising alarm (≥4).
- clk  in  1  system clock; all logic on posedge.
- rst_  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only when busy=0.
- we  in  1  1=write, 0=read; qualified by req.
- nb  in  [0:3]  segment number.
- ad  in  [0:15]  word address.
- wdata  in  [0:15]  write data.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- alarm  out  1  valid with done; 1=no answer/no release.
- rdata  out  [0:15]  read data, true polarity; held until the next read completes.
- nb_, ad_, rdt_  out  [0:3]/[0:15]/[0:15]  bus lines, active-low (inverted nb/ad/wdata).
- r_, w_, s_  out  1  bus strobes, active-low; s_ is permanently 1.
- ddt_  in  [0:15]  read data from slave, active-low.
- ok_  in  1  slave acknowledge, active-low.

## Operation
- All bus outputs are registered.
- Reset values:
  - nb_=4'hF, ad_=rdt_=16'hFFFF;
  - r_=w_=s_=1;
  - busy=done=alarm=0;
  - rdata=0;
  - state IDLE.
- States:
  - IDLE: on req, latch nb/ad/wdata/we inverted onto the bus, set busy, go to STROBE.
  - STROBE: r_ (read) or w_ (write) driven low. Timeout counter runs from 0.
    - If ok_=0 is sampled: for a read, capture rdata<=~ddt_ in the same edge; drive the strobe high; clear the counter; go to RELEASE.
    - If the counter reaches TIMEOUT-1 with ok_=1: drive the strobe high, set the alarm flag, go to RELEASE.
  - RELEASE: strobes high; address/data lines unchanged.
    - If ok_=1 is sampled: go to IDLE, pulse done with the alarm flag, clear busy, return bus lines to all-ones.
    - If ok_ stays 0 for TIMEOUT cycles: same exit, with alarm=1.
- ok_ is ignored in IDLE; a spurious low ok_ does not start anything.
- Address, data and nb_ lines are stable from the first strobe cycle until RELEASE exits. Never change them while a strobe is low.
- r_ and w_ are never low simultaneously.
- On alarm during a read, rdata is not updated.
- A req present in the same cycle as done is accepted. busy=0 in that cycle, so back-to-back transactions are legal.
- rst_ low mid-transaction forces all strobes high and lines to all-ones immediately (asynchronous). No done pulse is generated.

## Timing
- Cycle 0: req accepted.
- Cycle 1: strobe low.
- Against a slave answering at edge k after strobe: ok_ seen at end of cycle k, strobe high in cycle k+1, done in cycle k+2 if ok_ has released.
- With the SRAM memory module, read and write both show ok_ low in cycle 3; done is in cycle 5 (5-cycle transaction).
- Timeout path: strobe held low for exactly TIMEOUT cycles; done+alarm at cycle TIMEOUT+2 if ok_ is high.
- done and alarm are single-cycle pulses. rdata is valid from the done cycle onward.

## Structure
- Shared package mera_bus_pkg holds:
  - state enum (IDLE, STROBE, RELEASE);
  - bus-idle constants (NB_IDLE=4'hF, WORD_IDLE=16'hFFFF).
- One natural sub-module: bus_timeout, a clearable up-counter with terminal-count output, parameterised by TIMEOUT. It is shared with future bus masters (e.g. I/O channel).

## Test plan
- Read via SRAM model preloaded mem[16'h0123]=16'hBEEF, nb=0, ad=16'h0123:
  - ad_=16'hFEDC while r_=0;
  - done at cycle 5, rdata=16'hBEEF, alarm=0.
- Write ad=16'h0040, wdata=16'h1234 then read back:
  - rdt_=16'hEDCB during w_=0;
  - readback 16'h1234;
  - w_ and r_ never low together.
- No slave (ok_ tied 1), TIMEOUT=8, read:
  - r_ low exactly 8 cycles;
  - done+alarm=1 at cycle 10;
  - rdata unchanged.
- Stuck ok_=0 after ack: strobe released, then done+alarm after TIMEOUT cycles in RELEASE.
- Back-to-back: req held high for two writes. Second accepted in first's done cycle; strobes high ≥1 cycle between transactions.
- rst_ pulsed low while r_=0 in STROBE:
  - r_=1, ad_=16'hFFFF, busy=0 asynchronously;
  - no done;
  - next request completes normally.
